// File: rtl/pkg_bus.sv
// Instruction-bus operation encoding shared by the decoder and the load/store unit.
package pkg_bus;
    typedef enum logic [1:0] {NONE, FETCH, STORE} op_t;
endpackage

// File: rtl/pkg_ram.sv
// RAM-side shared types: byte address width, access size encoding and its byte count.
package pkg_ram;
    localparam int RAM_ADDRW = 16;

    typedef enum logic [1:0] {BYTE, WORD, LONG, QUAD} data_type_t;

    function automatic logic [3:0] size_bytes(data_type_t dt);
        case (dt)
            BYTE:    return 4'd1;
            WORD:    return 4'd2;
            LONG:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction
endpackage

// File: rtl/pkg_reg.sv
// Register file geometry.
package pkg_reg;
    localparam int REG_ADDRW = 5;
endpackage

// File: rtl/if_instr_bus.sv
// Decoder -> load/store unit operation fields; valid/ready travel as plain ports.
interface if_instr_bus;
    pkg_bus::op_t                  op;
    pkg_ram::data_type_t           data_type;
    logic [pkg_reg::REG_ADDRW-1:0] data_reg;
    logic [pkg_reg::REG_ADDRW-1:0] addr_reg;
    logic [pkg_ram::RAM_ADDRW-1:0] addr_offset;

    modport server (input op, data_type, data_reg, addr_reg, addr_offset);
    modport client (output op, data_type, data_reg, addr_reg, addr_offset);
endinterface

// File: rtl/bus_addr_gen.sv
// Combinational address helper: effective address, alignment, per-beat address and byte lane.
module bus_addr_gen #(
    parameter int RAM_ADDRW = pkg_ram::RAM_ADDRW
) (
    input  logic [RAM_ADDRW-1:0] base,
    input  logic [RAM_ADDRW-1:0] offset,
    input  logic [3:0]           size,
    input  logic [RAM_ADDRW-1:0] ea_q,
    input  logic [2:0]           beat,
    input  logic [2:0]           last,
    output logic [RAM_ADDRW-1:0] ea,
    output logic                 aligned,
    output logic [RAM_ADDRW-1:0] beat_addr,
    output logic [2:0]           lane
);
    logic [2:0] mask;

    // size is a power of two up to 8, so size-1 is the low-bit alignment mask
    assign mask      = 3'(size - 4'd1);
    assign ea        = base + offset;
    assign aligned   = (ea[2:0] & mask) == 3'd0;
    assign beat_addr = ea_q + {{(RAM_ADDRW-3){1'b0}}, beat};
    // big-endian: beat 0 carries the most significant byte
    assign lane      = last - beat;
endmodule

// File: rtl/bus_ctrl.sv
// Load/store unit: moves 1/2/4/8 big-endian bytes between the register file and a byte-wide RAM.
module bus_ctrl
    import pkg_bus::*;
    import pkg_ram::*;
#(
    parameter int REG_DATAW = 64,
    parameter int RAM_ADDRW = pkg_ram::RAM_ADDRW,
    parameter int REG_ADDRW = pkg_reg::REG_ADDRW
) (
    input  logic                 clk,
    input  logic                 rst,
    if_instr_bus.server          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic                 done,
    output logic                 misaligned,
    output logic [REG_ADDRW-1:0] rd_addr0,
    input  logic [REG_DATAW-1:0] rd_data0,
    output logic [REG_ADDRW-1:0] rd_addr1,
    input  logic [REG_DATAW-1:0] rd_data1,
    output logic                 wr_en,
    output logic [REG_ADDRW-1:0] wr_addr,
    output logic [REG_DATAW-1:0] wr_data,
    output logic                 ram_req,
    output logic                 ram_we,
    output logic [RAM_ADDRW-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] RD_LAST = 3'd2;
    localparam logic [2:0] WB      = 3'd3;
    localparam logic [2:0] WR      = 3'd4;
    localparam logic [2:0] FIN     = 3'd5;

    logic [2:0]           state, cnt, last_q;
    logic [REG_ADDRW-1:0] dreg_q;
    logic [REG_DATAW-1:0] src_q, data_q;
    logic [RAM_ADDRW-1:0] ea_q, ea, beat_addr;
    logic                 mis_q, aligned, is_mem;
    logic [3:0]           size;
    logic [2:0]           lane;
    logic                 unused_base_hi;

    assign unused_base_hi = ^rd_data0[REG_DATAW-1:RAM_ADDRW];
    assign size   = size_bytes(instr.data_type);
    assign is_mem = (instr.op == FETCH) || (instr.op == STORE);

    bus_addr_gen #(.RAM_ADDRW(RAM_ADDRW)) u_addr_gen (
        .base      (rd_data0[RAM_ADDRW-1:0]),
        .offset    (instr.addr_offset),
        .size      (size),
        .ea_q      (ea_q),
        .beat      (cnt),
        .last      (last_q),
        .ea        (ea),
        .aligned   (aligned),
        .beat_addr (beat_addr),
        .lane      (lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last_q <= '0;
            dreg_q <= '0;
            src_q  <= '0;
            data_q <= '0;
            ea_q   <= '0;
            mis_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    last_q <= 3'(size - 4'd1);
                    dreg_q <= instr.data_reg;
                    src_q  <= rd_data1;
                    ea_q   <= ea;
                    data_q <= '0;
                    cnt    <= '0;
                    mis_q  <= is_mem && !aligned;
                    if (!is_mem || !aligned)  state <= FIN;
                    else if (instr.op == FETCH) state <= RD;
                    else                        state <= WR;
                end
                RD: begin
                    // read data lags its request by one cycle; beat 0 has nothing to capture yet
                    if (cnt != 3'd0) data_q <= {data_q[REG_DATAW-9:0], ram_rdata};
                    if (cnt == last_q) state <= RD_LAST;
                    else               cnt   <= cnt + 3'd1;
                end
                RD_LAST: begin
                    data_q <= {data_q[REG_DATAW-9:0], ram_rdata};
                    state  <= WB;
                end
                WR: begin
                    if (cnt == last_q) state <= FIN;
                    else               cnt   <= cnt + 3'd1;
                end
                WB, FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign instr_ready = (state == IDLE);
    assign done        = (state == WB) || (state == FIN);
    assign misaligned  = (state == FIN) && mis_q;
    assign rd_addr0    = instr.addr_reg;
    assign rd_addr1    = instr.data_reg;
    assign ram_req     = (state == RD) || (state == WR);
    assign ram_we      = (state == WR);
    assign ram_addr    = beat_addr;
    assign ram_wdata   = src_q[{lane, 3'b000} +: 8];
    // register 0 is hardwired zero, so its writeback is dropped
    assign wr_en       = (state == WB) && (dreg_q != '0);
    assign wr_addr     = dreg_q;
    assign wr_data     = data_q;
endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl with a byte RAM model and a behavioural register file.
module tb_bus_ctrl;
    import pkg_bus::*;
    import pkg_ram::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready, done, misaligned;
    logic [4:0]  rd_addr0, rd_addr1, wr_addr;
    logic [63:0] rd_data0, rd_data1, wr_data;
    logic        wr_en, ram_req, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [63:0] regs [0:31];
    logic [7:0]  mem  [0:65535];
    logic        pk_en;
    logic [15:0] pk_addr;
    logic [7:0]  pk_data;

    logic        s_req [1:16], s_we [1:16], s_done [1:16], s_mis [1:16], s_wen [1:16], s_rdy [1:16];
    logic [15:0] s_addr [1:16];
    logic [7:0]  s_wd [1:16];
    logic [4:0]  s_waddr [1:16];
    logic [63:0] s_wdata [1:16];

    int checks = 0;
    int errors = 0;

    if_instr_bus ib ();

    bus_ctrl dut (
        .clk(clk), .rst(rst), .instr(ib), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .done(done), .misaligned(misaligned), .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    always @(posedge clk) begin
        if (pk_en) mem[pk_addr] <= pk_data;
        else if (ram_req && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_req && !ram_we) ram_rdata <= mem[ram_addr];
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic issue(input op_t op, input data_type_t dt, input logic [4:0] areg,
                         input logic [15:0] off, input logic [4:0] dreg);
        @(posedge clk); #1;
        ib.op = op; ib.data_type = dt; ib.addr_reg = areg; ib.addr_offset = off; ib.data_reg = dreg;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic sample(input int k);
        s_req[k] = ram_req; s_we[k] = ram_we; s_addr[k] = ram_addr; s_wd[k] = ram_wdata;
        s_done[k] = done; s_mis[k] = misaligned; s_wen[k] = wr_en; s_rdy[k] = instr_ready;
        s_waddr[k] = wr_addr; s_wdata[k] = wr_data;
    endtask

    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            sample(k);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || misaligned !== 1'b0 || wr_en !== 1'b0 ||
            ram_req !== 1'b0 || ram_we !== 1'b0 || wr_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b mis=%b wr_en=%b req=%b we=%b wr_data=%h, required 1 0 0 0 0 0 0",
                     instr_ready, done, misaligned, wr_en, ram_req, ram_we, wr_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b done=%b, required ready=1 done=0", instr_ready, done);
        end
    endtask

    task automatic test_byte_fetch;
        regs[1] = 64'h100;
        poke(16'h0103, 8'hA5);
        issue(FETCH, BYTE, 5'd1, 16'd3, 5'd5);
        run(5);
        checks++;
        if (s_req[1] !== 1'b1 || s_we[1] !== 1'b0 || s_addr[1] !== 16'h0103) begin
            errors++;
            $display("FAIL byte_fetch_read: req=%b we=%b addr=%h, required 1 0 0103", s_req[1], s_we[1], s_addr[1]);
        end
        checks++;
        if (s_req[2] !== 1'b0 || s_done[2] !== 1'b0 || s_wen[2] !== 1'b0) begin
            errors++;
            $display("FAIL byte_fetch_t2: req=%b done=%b wr_en=%b, required 0 0 0", s_req[2], s_done[2], s_wen[2]);
        end
        checks++;
        if (s_wen[3] !== 1'b1 || s_waddr[3] !== 5'd5 || s_wdata[3] !== 64'hA5 || s_done[3] !== 1'b1) begin
            errors++;
            $display("FAIL byte_fetch_wb: wr_en=%b addr=%0d data=%h done=%b, required 1 5 00000000000000a5 1",
                     s_wen[3], s_waddr[3], s_wdata[3], s_done[3]);
        end
        checks++;
        if (s_rdy[1] !== 1'b0 || s_rdy[3] !== 1'b0 || s_rdy[4] !== 1'b1 || s_wen[4] !== 1'b0 || s_done[4] !== 1'b0) begin
            errors++;
            $display("FAIL byte_fetch_ready: rdy1=%b rdy3=%b rdy4=%b wen4=%b done4=%b, required 0 0 1 0 0",
                     s_rdy[1], s_rdy[3], s_rdy[4], s_wen[4], s_done[4]);
        end
    endtask

    task automatic test_quad_fetch;
        regs[2] = 64'h1F0;
        for (int i = 0; i < 8; i++) poke(16'h0200 + 16'(i), 8'(i + 1));
        issue(FETCH, QUAD, 5'd2, 16'h0010, 5'd7);
        run(11);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (s_req[k] !== 1'b1 || s_we[k] !== 1'b0 || s_addr[k] !== 16'h0200 + 16'(k - 1)) begin
                errors++;
                $display("FAIL quad_fetch_read%0d: req=%b we=%b addr=%h, required 1 0 %h",
                         k, s_req[k], s_we[k], s_addr[k], 16'h0200 + 16'(k - 1));
            end
        end
        checks++;
        if (s_req[9] !== 1'b0 || s_wen[9] !== 1'b0 || s_done[9] !== 1'b0) begin
            errors++;
            $display("FAIL quad_fetch_t9: req=%b wr_en=%b done=%b, required 0 0 0", s_req[9], s_wen[9], s_done[9]);
        end
        checks++;
        if (s_wen[10] !== 1'b1 || s_waddr[10] !== 5'd7 || s_wdata[10] !== 64'h0102030405060708 || s_done[10] !== 1'b1) begin
            errors++;
            $display("FAIL quad_fetch_wb: wr_en=%b addr=%0d data=%h done=%b, required 1 7 0102030405060708 1",
                     s_wen[10], s_waddr[10], s_wdata[10], s_done[10]);
        end
    endtask

    task automatic test_long_store;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        regs[3] = 64'h40;
        regs[9] = 64'h11223344DEADBEEF;
        issue(STORE, LONG, 5'd3, 16'd0, 5'd9);
        run(6);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (s_req[k] !== 1'b1 || s_we[k] !== 1'b1 || s_addr[k] !== 16'h0040 + 16'(k - 1) || s_wd[k] !== exp_b[k-1]) begin
                errors++;
                $display("FAIL long_store_write%0d: req=%b we=%b addr=%h wdata=%h, required 1 1 %h %h",
                         k, s_req[k], s_we[k], s_addr[k], s_wd[k], 16'h0040 + 16'(k - 1), exp_b[k-1]);
            end
        end
        checks++;
        if (s_done[5] !== 1'b1 || s_req[5] !== 1'b0 || s_done[4] !== 1'b0 || s_mis[5] !== 1'b0) begin
            errors++;
            $display("FAIL long_store_done: done5=%b req5=%b done4=%b mis5=%b, required 1 0 0 0",
                     s_done[5], s_req[5], s_done[4], s_mis[5]);
        end
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (s_wen[k] !== 1'b0) begin
                errors++;
                $display("FAIL long_store_no_wb%0d: wr_en=%b, required 0", k, s_wen[k]);
            end
        end
        checks++;
        if ({mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL long_store_mem: got %h%h%h%h, required deadbeef",
                     mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]);
        end
    endtask

    task automatic test_misaligned;
        regs[4] = 64'h100;
        issue(FETCH, WORD, 5'd4, 16'd1, 5'd8);
        run(4);
        checks++;
        if (s_done[1] !== 1'b1 || s_mis[1] !== 1'b1 || s_rdy[1] !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_pulse: done=%b mis=%b rdy=%b, required 1 1 0", s_done[1], s_mis[1], s_rdy[1]);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (s_req[k] !== 1'b0 || s_wen[k] !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_no_access%0d: req=%b wr_en=%b, required 0 0", k, s_req[k], s_wen[k]);
            end
        end
        checks++;
        if (s_rdy[2] !== 1'b1 || s_done[2] !== 1'b0 || s_mis[2] !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_after: rdy=%b done=%b mis=%b, required 1 0 0", s_rdy[2], s_done[2], s_mis[2]);
        end
    endtask

    task automatic test_none_op;
        issue(NONE, WORD, 5'd4, 16'd1, 5'd8);
        run(3);
        checks++;
        if (s_done[1] !== 1'b1 || s_mis[1] !== 1'b0 || s_req[1] !== 1'b0 || s_wen[1] !== 1'b0 || s_rdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL none_op: done=%b mis=%b req=%b wr_en=%b rdy2=%b, required 1 0 0 0 1",
                     s_done[1], s_mis[1], s_req[1], s_wen[1], s_rdy[2]);
        end
    endtask

    task automatic test_zero_reg;
        issue(FETCH, BYTE, 5'd1, 16'd3, 5'd0);
        run(5);
        checks++;
        if (s_req[1] !== 1'b1 || s_addr[1] !== 16'h0103) begin
            errors++;
            $display("FAIL zero_reg_read: req=%b addr=%h, required 1 0103", s_req[1], s_addr[1]);
        end
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (s_wen[k] !== 1'b0) begin
                errors++;
                $display("FAIL zero_reg_no_wb%0d: wr_en=%b, required 0", k, s_wen[k]);
            end
        end
        checks++;
        if (s_done[3] !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg_done: done=%b, required 1", s_done[3]);
        end
    endtask

    task automatic test_addr_wrap;
        regs[5] = 64'hABCD00000000FFFF;
        poke(16'h0002, 8'h12);
        poke(16'h0003, 8'h34);
        issue(FETCH, WORD, 5'd5, 16'd3, 5'd6);
        run(5);
        checks++;
        if (s_addr[1] !== 16'h0002 || s_addr[2] !== 16'h0003 || s_req[1] !== 1'b1 || s_req[2] !== 1'b1 || s_req[3] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reads: addr1=%h addr2=%h req=%b%b%b, required 0002 0003 110",
                     s_addr[1], s_addr[2], s_req[1], s_req[2], s_req[3]);
        end
        checks++;
        if (s_wen[4] !== 1'b1 || s_waddr[4] !== 5'd6 || s_wdata[4] !== 64'h1234 || s_done[4] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_wb: wr_en=%b addr=%0d data=%h done=%b, required 1 6 0000000000001234 1",
                     s_wen[4], s_waddr[4], s_wdata[4], s_done[4]);
        end
    endtask

    task automatic test_reset_mid_op;
        regs[3]  = 64'h80;
        regs[10] = 64'h0102030405060708;
        poke(16'h0083, 8'hEE);
        issue(STORE, QUAD, 5'd3, 16'd0, 5'd10);
        sample(1); @(posedge clk); #1;
        sample(2); @(posedge clk); #1;
        sample(3);
        rst = 1'b1;
        @(posedge clk); #1;
        sample(4);
        rst = 1'b0;
        @(posedge clk); #1;
        sample(5); @(posedge clk); #1;
        sample(6); @(posedge clk); #1;
        checks++;
        if (s_req[3] !== 1'b1 || s_addr[3] !== 16'h0082) begin
            errors++;
            $display("FAIL rst_mid_pre: req=%b addr=%h, required 1 0082", s_req[3], s_addr[3]);
        end
        for (int k = 4; k <= 6; k++) begin
            checks++;
            if (s_req[k] !== 1'b0 || s_done[k] !== 1'b0 || s_rdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_abort%0d: req=%b done=%b rdy=%b, required 0 0 1", k, s_req[k], s_done[k], s_rdy[k]);
            end
        end
        checks++;
        if (mem[16'h0082] !== 8'h03 || mem[16'h0083] !== 8'hEE) begin
            errors++;
            $display("FAIL rst_mid_mem: mem82=%h mem83=%h, required 03 ee", mem[16'h0082], mem[16'h0083]);
        end
        issue(FETCH, BYTE, 5'd1, 16'd3, 5'd4);
        run(4);
        checks++;
        if (s_wen[3] !== 1'b1 || s_waddr[3] !== 5'd4 || s_wdata[3] !== 64'hA5 || s_done[3] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_followup: wr_en=%b addr=%0d data=%h done=%b, required 1 4 00000000000000a5 1",
                     s_wen[3], s_waddr[3], s_wdata[3], s_done[3]);
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        pk_en = 1'b0; pk_addr = '0; pk_data = '0;
        ib.op = NONE; ib.data_type = BYTE; ib.addr_reg = '0; ib.addr_offset = '0; ib.data_reg = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset;
        test_byte_fetch;
        test_quad_fetch;
        test_long_store;
        test_misaligned;
        test_none_op;
        test_zero_reg;
        test_addr_wrap;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
